// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Load/store sequencer between the multicycle CPU control FSM and a word-wide
//   data memory. It adds byte and halfword loads with sign or zero extension,
//   performs sub-word stores as a read-modify-write, and rejects misaligned or
//   out-of-range accesses without touching memory.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req          access request, sampled only while idle
//   op[2:0]      0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
//   addr[31:0]   byte address
//   wdata[31:0]  store data (SH uses [15:0], SB uses [7:0])
//   busy         high whenever not idle
//   done         one-cycle completion pulse
//   err          valid with done: access rejected, memory untouched
//   rdata[31:0]  load result, held until the next load completes
//   mem_addr     word address to memory: {latched addr[31:2], 2'b00}
//   mem_wdata    write data to memory
//   mem_we       write enable to memory, decoded from state only
//   mem_rdata    combinational read data from memory
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int AW          = 12,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_DONE, S_ERR
  } state_e;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;     // only sub-word stores need the data after accept
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wdata_q, merge_d;

  logic accept, is_load, bad_align, bad_range;

  assign accept  = (state_q == S_IDLE) && req;
  assign is_load = (op <= OP_LBU);

  // Request checks look at the live inputs: they only matter at the accept edge.
  assign bad_align = (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00)) ||
                     (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]);
  assign bad_range = CHECK_RANGE && (|addr[31:AW]);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bad_align || bad_range) state_d = S_ERR;
          else if (is_load)           state_d = S_LOAD;
          else if (op == OP_SW)       state_d = S_WRITE;
          else                        state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_DONE;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state register only
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE) || (state_q == S_ERR);
    err    = (state_q == S_ERR);
    mem_we = (state_q == S_WRITE);
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction and store lane merge (little-endian lanes)
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte = mem_rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    rdata_d = mem_rdata;
    unique case (op_q)
      OP_LH:   rdata_d = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  rdata_d = {16'h0000, ld_half};
      OP_LB:   rdata_d = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  rdata_d = {24'h000000, ld_byte};
      default: rdata_d = mem_rdata;
    endcase

    merge_d = mem_rdata;
    if (op_q == OP_SB)      merge_d[8*addr_q[1:0] +: 8]    = wdata_q[7:0];
    else if (op_q == OP_SH) merge_d[16*addr_q[1] +: 16]    = wdata_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 16'd0;
      rdata_q     <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      if (accept) begin
        op_q    <= op;
        addr_q  <= addr;
        wdata_q <= wdata[15:0];
        if ((op == OP_SW) && !bad_align && !bad_range) mem_wdata_q <= wdata;
      end
      if (state_q == S_LOAD)   rdata_q     <= rdata_d;
      if (state_q == S_RMW_RD) mem_wdata_q <= merge_d;
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;

endmodule
